// File: rtl/oflow_feature_extraction_sb_reader.sv
// Read-side sequencer for the feature-extraction scoreboard: walks rows 0..n-1
// through the shared address port and streams each word out over valid/ready.
module oflow_feature_extraction_sb_reader #(
  parameter int FE_WIDTH = 36,
  parameter int ROW_LEN  = 5,
  parameter int MAX_ROWS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW_LEN:0]    num_rows,
  input  logic                ready_new_frame,
  output logic                sb_rd_req,
  input  logic                sb_rd_gnt,
  output logic [ROW_LEN-1:0]  sb_addr,
  input  logic [FE_WIDTH-1:0] sb_data,
  output logic                fe_valid,
  input  logic                fe_ready,
  output logic [FE_WIDTH-1:0] fe_data,
  output logic [ROW_LEN-1:0]  fe_row,
  output logic                fe_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ROW_LEN:0] MAX_N = (ROW_LEN + 1)'(MAX_ROWS);
  localparam logic [ROW_LEN:0] ONE   = (ROW_LEN + 1)'(1);

  state_t               r_state;
  state_t               w_state_next;
  logic [ROW_LEN:0]     r_n;
  logic [ROW_LEN:0]     r_row_cnt;
  logic                 r_valid;
  logic                 r_last;
  logic [FE_WIDTH-1:0]  r_data;
  logic [ROW_LEN-1:0]   r_row;

  logic [ROW_LEN:0]     w_clamped;
  logic                 w_out_free;
  logic                 w_req;
  logic                 w_capture;
  logic                 w_accept;
  logic                 w_last_row;
  logic                 w_start_pass;

  assign w_clamped    = (num_rows > MAX_N) ? MAX_N : num_rows;
  // The output stage can take a new word if empty or being drained this cycle.
  assign w_out_free   = !r_valid || fe_ready;
  assign w_req        = (r_state == S_FETCH) && w_out_free;
  assign w_capture    = w_req && sb_rd_gnt;
  assign w_accept     = r_valid && fe_ready;
  assign w_last_row   = (r_row_cnt == (r_n - ONE));
  assign w_start_pass = (r_state == S_IDLE) && start && !ready_new_frame;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_pass) begin
          w_state_next = (num_rows == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_capture && w_last_row) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_accept && r_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (ready_new_frame) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ready_new_frame) begin
      r_n       <= '0;
      r_row_cnt <= '0;
    end else if (w_start_pass) begin
      r_n       <= w_clamped;
      r_row_cnt <= '0;
    end else if (w_capture) begin
      r_row_cnt <= r_row_cnt + ONE;
    end
  end

  // A capture in the same cycle as an accept refills the stage without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_row   <= '0;
    end else if (ready_new_frame) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_last  <= w_last_row;
      r_data  <= sb_data;
      r_row   <= r_row_cnt[ROW_LEN-1:0];
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign sb_rd_req = w_req;
  assign sb_addr   = w_req ? r_row_cnt[ROW_LEN-1:0] : '0;
  assign fe_valid  = r_valid;
  assign fe_data   = r_data;
  assign fe_row    = r_row;
  assign fe_last   = r_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
